id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning operand data path width (instruction width fixed at 32).
REQ-002 SHALL have ports i_clk in 1 clock, and i_reset in 1, which is asynchronous and active-high.
REQ-003 SHALL have port i_valid in 1: the IF/ID stage holds a valid instruction.
REQ-004 SHALL have port i_instr in 32: instruction word from IF/ID.
REQ-005 SHALL have ports i_src1, i_src2 in DATA_W: register-file read data for rs, rt.
REQ-006 SHALL have ports i_wb_addr in 5 and i_wb_data in DATA_W: same-cycle writeback (write occurs when addr != 0).
REQ-007 SHALL have ports i_flush in 1 (taken-branch kill from EX) and i_hold in 1 (downstream freeze).
REQ-008 SHALL have port o_stall out 1: freeze PC and IF/ID.
REQ-009 SHALL have ports o_valid out 1, o_src1 out DATA_W, o_src2 out DATA_W, and o_imm out 32: latched EX operands.
REQ-010 SHALL have ports o_rs, o_rt, o_dest out 5: source and destination register numbers for EX forwarding and WB.
REQ-011 SHALL have ports o_alu_op out 3, o_alu_src out 1 (1 = immediate as B), o_mem_read, o_mem_write, o_reg_write, o_illegal out 1.

Function
REQ-012 SHALL decode R-type (opcode 0): funct ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT.
REQ-013 SHALL decode I-type ADDI/ADDIU/ANDI/ORI/XORI/SLTI/LUI/LW/SW; all other encodings set o_illegal=1 with o_valid=0 and all controls 0.
REQ-014 SHALL use dest = rd for R-type, rt for I-type, 0 for SW. o_reg_write=1 only when o_valid=1 and dest != 0.
REQ-015 SHALL form immediates as: ANDI/ORI/XORI zero-extend; LUI {imm,16'h0}; all others sign-extend.
REQ-016 SHALL register o_src1 = i_wb_data when i_wb_addr != 0 and == rs, else i_src1 (WB bypass). Same rule for o_src2/rt. rs/rt = 0 always latch 0.
REQ-017 SHALL assert o_stall combinationally when o_valid & o_mem_read & o_dest != 0 & i_valid and (rs == o_dest, or rt == o_dest for R-type/SW); o_stall SHALL also be asserted whenever i_hold = 1.
REQ-018 SHALL apply, per rising edge, priority i_flush > i_hold > load-use > normal load.
REQ-019 SHALL, on flush, load a bubble: o_valid=0; o_mem_read, o_mem_write, o_reg_write, o_illegal = 0; datapath fields don't-care.
REQ-020 SHALL, on hold without flush, keep all outputs unchanged.
REQ-021 SHALL, on load-use without flush or hold, load a bubble; the stall therefore lasts exactly one cycle.
REQ-022 SHALL, on normal load, capture decoded fields with o_valid=i_valid; when i_valid=0, load a bubble.
REQ-023 SHALL have latency: an instruction accepted at edge N appears on outputs after edge N.

Reset
REQ-024 SHALL, on i_reset, clear every registered output to 0 immediately, independent of the clock, so that a bubble is held; o_stall=0 (when i_hold=0).
REQ-025 SHALL, when reset arrives mid-stall, discard the stalled instruction; IF/ID refetch is the upstream's responsibility.

Structure
REQ-026 SHALL keep opcode/funct constants and the ALU_ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, LUI=7 codes in shared package mips_pkg.
REQ-027 SHALL place combinational decode in sub-module id_decoder; hazard logic, bypass and the pipeline register SHALL be in id_ex_stage.

Verification
REQ-028 SHALL test: ADDI $t0,$zero,-5 -> o_imm=32'hFFFF_FFFB, o_alu_op=0, o_alu_src=1, o_dest=8, o_reg_write=1.
REQ-029 SHALL test: LW $t0 in EX then ADD $t1,$t0,$t2 in ID -> o_stall=1 one cycle, bubble in EX, ADD latched next edge.
REQ-030 SHALL test: i_wb_addr=9, i_wb_data=32'hDEAD_BEEF while rs=9, i_src1=0 -> o_src1=32'hDEAD_BEEF.
REQ-031 SHALL test: i_flush and i_hold asserted together -> bubble loaded, o_valid=0.
REQ-032 SHALL test: opcode 6'h3F -> o_illegal=1, o_valid=0, o_reg_write=0.
REQ-033 SHALL test: i_reset pulsed between clock edges during a valid SW -> all outputs 0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode/funct constants, ALU codes and ID/EX pipeline record
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOR = 3'd5,
        ALU_SLT = 3'd6,
        ALU_LUI = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_SEXT,
        IMM_ZEXT,
        IMM_UPPER
    } imm_kind_e;

    // Control half of the ID/EX register; operand data lives beside it since its width is a parameter.
    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        alu_src;
        alu_op_e     alu_op;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode bundle between the instruction decoder and the ID/EX stage
interface id_ex_stage_if;
    import mips_pkg::*;

    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
    logic        uses_rt;

    modport master (
        input  instr,
        output rs, rt, dest, imm, alu_op, alu_src, mem_read, mem_write, illegal, uses_rt
    );

    modport slave (
        output instr,
        input  rs, rt, dest, imm, alu_op, alu_src, mem_read, mem_write, illegal, uses_rt
    );
endinterface

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational decode of one instruction word into EX controls
module id_decoder
    import mips_pkg::*;
(
    id_ex_stage_if.master dec
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [4:0]  unused_shamt;
    imm_kind_e   imm_kind;

    assign opcode       = dec.instr[31:26];
    assign funct        = dec.instr[5:0];
    assign imm16        = dec.instr[15:0];
    assign unused_shamt = dec.instr[10:6];

    always_comb begin
        dec.rs        = dec.instr[25:21];
        dec.rt        = dec.instr[20:16];
        dec.dest      = dec.instr[20:16];
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b0;
        dec.mem_read  = 1'b0;
        dec.mem_write = 1'b0;
        dec.illegal   = 1'b0;
        dec.uses_rt   = 1'b0;
        imm_kind      = IMM_SEXT;

        case (opcode)
            OP_RTYPE: begin
                dec.dest    = dec.instr[15:11];
                dec.uses_rt = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
                    FN_AND:          dec.alu_op = ALU_AND;
                    FN_OR:           dec.alu_op = ALU_OR;
                    FN_XOR:          dec.alu_op = ALU_XOR;
                    FN_NOR:          dec.alu_op = ALU_NOR;
                    FN_SLT:          dec.alu_op = ALU_SLT;
                    default:         dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: dec.alu_src = 1'b1;
            OP_SLTI: begin
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_SLT;
            end
            OP_ANDI: begin
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_AND;
                imm_kind    = IMM_ZEXT;
            end
            OP_ORI: begin
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_OR;
                imm_kind    = IMM_ZEXT;
            end
            OP_XORI: begin
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_XOR;
                imm_kind    = IMM_ZEXT;
            end
            OP_LUI: begin
                dec.alu_src = 1'b1;
                dec.alu_op  = ALU_LUI;
                imm_kind    = IMM_UPPER;
            end
            OP_LW: begin
                dec.alu_src  = 1'b1;
                dec.mem_read = 1'b1;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.dest      = 5'd0;
                dec.uses_rt   = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // Illegal words must not leave any side-effecting control behind; uses_rt still follows the opcode.
        if (dec.illegal) begin
            dec.alu_op    = ALU_ADD;
            dec.alu_src   = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.dest      = 5'd0;
        end

        case (imm_kind)
            IMM_ZEXT:  dec.imm = {16'h0000, imm16};
            IMM_UPPER: dec.imm = {imm16, 16'h0000};
            default:   dec.imm = {{16{imm16[15]}}, imm16};
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection and WB bypass
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_src1,
    input  logic [DATA_W-1:0] i_src2,
    input  logic [4:0]        i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_flush,
    input  logic              i_hold,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_src1,
    output logic [DATA_W-1:0] o_src2,
    output logic [31:0]       o_imm,
    output logic [4:0]        o_rs,
    output logic [4:0]        o_rt,
    output logic [4:0]        o_dest,
    output logic [2:0]        o_alu_op,
    output logic              o_alu_src,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_reg_write,
    output logic              o_illegal
);

    id_ex_stage_if dec_if ();

    assign dec_if.instr = i_instr;

    id_decoder u_id_decoder (
        .dec(dec_if)
    );

    ex_ctrl_t          ctrl_q, ctrl_d, captured;
    logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
    logic [DATA_W-1:0] byp1, byp2;
    logic              load_use;

    // A load in EX cannot forward to the instruction behind it; hold that one in ID for a cycle.
    assign load_use = ctrl_q.valid && ctrl_q.mem_read && (ctrl_q.dest != 5'd0) && i_valid &&
                      ((dec_if.rs == ctrl_q.dest) || (dec_if.uses_rt && (dec_if.rt == ctrl_q.dest)));

    assign o_stall = i_hold || load_use;

    always_comb begin
        byp1 = i_src1;
        byp2 = i_src2;
        if (dec_if.rs == 5'd0)                byp1 = '0;
        else if (i_wb_addr == dec_if.rs)      byp1 = i_wb_data;
        if (dec_if.rt == 5'd0)                byp2 = '0;
        else if (i_wb_addr == dec_if.rt)      byp2 = i_wb_data;
    end

    always_comb begin
        captured           = '0;
        captured.valid     = !dec_if.illegal;
        captured.illegal   = dec_if.illegal;
        captured.mem_read  = dec_if.mem_read;
        captured.mem_write = dec_if.mem_write;
        captured.reg_write = !dec_if.illegal && (dec_if.dest != 5'd0);
        captured.alu_src   = dec_if.alu_src;
        captured.alu_op    = dec_if.alu_op;
        captured.imm       = dec_if.imm;
        captured.rs        = dec_if.rs;
        captured.rt        = dec_if.rt;
        captured.dest      = dec_if.dest;
    end

    always_comb begin
        ctrl_d = ctrl_q;
        src1_d = src1_q;
        src2_d = src2_q;
        if (i_flush) begin
            ctrl_d = '0;
            src1_d = '0;
            src2_d = '0;
        end else if (i_hold) begin
            ctrl_d = ctrl_q;
        end else if (load_use || !i_valid) begin
            ctrl_d = '0;
            src1_d = '0;
            src2_d = '0;
        end else begin
            ctrl_d = captured;
            src1_d = byp1;
            src2_d = byp2;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctrl_q <= '0;
            src1_q <= '0;
            src2_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            src1_q <= src1_d;
            src2_q <= src2_d;
        end
    end

    assign o_valid     = ctrl_q.valid;
    assign o_src1      = src1_q;
    assign o_src2      = src2_q;
    assign o_imm       = ctrl_q.imm;
    assign o_rs        = ctrl_q.rs;
    assign o_rt        = ctrl_q.rt;
    assign o_dest      = ctrl_q.dest;
    assign o_alu_op    = ctrl_q.alu_op;
    assign o_alu_src   = ctrl_q.alu_src;
    assign o_mem_read  = ctrl_q.mem_read;
    assign o_mem_write = ctrl_q.mem_write;
    assign o_reg_write = ctrl_q.reg_write;
    assign o_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage against a mnemonic-level reference model
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        alu_src;
        logic [2:0]  alu_op;
        logic [31:0] imm;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_instr = '0;
    logic [31:0] i_src1 = '0, i_src2 = '0, i_wb_data = '0;
    logic [4:0]  i_wb_addr = '0;
    logic        i_flush = 1'b0, i_hold = 1'b0;
    logic        o_stall, o_valid, o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_illegal;
    logic [31:0] o_src1, o_src2, o_imm;
    logic [4:0]  o_rs, o_rt, o_dest;
    logic [2:0]  o_alu_op;

    int checks = 0;
    int failures = 0;
    ex_t st = '0;
    ex_t exp_q[$];
    logic stall_seen;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_instr(i_instr),
        .i_src1(i_src1), .i_src2(i_src2), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_flush(i_flush), .i_hold(i_hold), .o_stall(o_stall), .o_valid(o_valid),
        .o_src1(o_src1), .o_src2(o_src2), .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt),
        .o_dest(o_dest), .o_alu_op(o_alu_op), .o_alu_src(o_alu_src),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_reg_write(o_reg_write),
        .o_illegal(o_illegal)
    );

    id_ex_stage_if tb_dec_if ();
    assign tb_dec_if.instr = i_instr;
    id_decoder u_tb_dec (.dec(tb_dec_if));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: what EX should hold if this instruction word were accepted.
    function automatic ex_t model_accept(input logic [31:0] ins, input logic [31:0] s1, input logic [31:0] s2,
                                         input logic [4:0] wa, input logic [31:0] wd);
        ex_t e = '0;
        logic [5:0] op = ins[31:26];
        logic [15:0] i16 = ins[15:0];
        logic [31:0] sext = {{16{i16[15]}}, i16};
        logic legal = 1'b1;
        e.rs = ins[25:21];
        e.rt = ins[20:16];
        e.dest = ins[20:16];
        e.imm = sext;
        e.alu_src = 1'b1;
        if (op == 6'h00) begin
            e.dest = ins[15:11];
            e.alu_src = 1'b0;
            case (ins[5:0])
                6'h20, 6'h21: e.alu_op = 3'd0;
                6'h22, 6'h23: e.alu_op = 3'd1;
                6'h24: e.alu_op = 3'd2;
                6'h25: e.alu_op = 3'd3;
                6'h26: e.alu_op = 3'd4;
                6'h27: e.alu_op = 3'd5;
                6'h2A: e.alu_op = 3'd6;
                default: legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: e.alu_op = 3'd0;
                6'h0A: e.alu_op = 3'd6;
                6'h0C: begin e.alu_op = 3'd2; e.imm = {16'h0, i16}; end
                6'h0D: begin e.alu_op = 3'd3; e.imm = {16'h0, i16}; end
                6'h0E: begin e.alu_op = 3'd4; e.imm = {16'h0, i16}; end
                6'h0F: begin e.alu_op = 3'd7; e.imm = {i16, 16'h0}; end
                6'h23: e.mem_read = 1'b1;
                6'h2B: begin e.mem_write = 1'b1; e.dest = 5'd0; end
                default: legal = 1'b0;
            endcase
        end
        e.valid = legal;
        e.illegal = !legal;
        if (!legal) begin
            e.mem_read = 1'b0; e.mem_write = 1'b0; e.alu_src = 1'b0; e.alu_op = 3'd0; e.dest = 5'd0;
        end
        e.reg_write = legal && (e.dest != 5'd0);
        e.src1 = (e.rs == 5'd0) ? 32'h0 : ((wa == e.rs) ? wd : s1);
        e.src2 = (e.rt == 5'd0) ? 32'h0 : ((wa == e.rt) ? wd : s2);
        return e;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [4:0] wa, input logic [31:0] wd, input logic fl, input logic hd,
                        output logic stall_out);
        ex_t acc, nxt;
        logic lu;
        logic [5:0] op;
        @(negedge clk);
        i_valid = v; i_instr = ins; i_src1 = s1; i_src2 = s2;
        i_wb_addr = wa; i_wb_data = wd; i_flush = fl; i_hold = hd;
        #1;
        acc = model_accept(ins, s1, s2, wa, wd);
        op = ins[31:26];
        lu = st.valid && st.mem_read && (st.dest != 5'd0) && v &&
             ((ins[25:21] == st.dest) || ((op == 6'h00 || op == 6'h2B) && ins[20:16] == st.dest));
        stall_out = o_stall;
        chk("stall", {31'b0, o_stall}, {31'b0, (hd | lu)});
        chk("dec_illegal", {31'b0, tb_dec_if.illegal}, {31'b0, acc.illegal});
        if (fl)            nxt = '0;
        else if (hd)       nxt = st;
        else if (lu || !v) nxt = '0;
        else               nxt = acc;
        st = nxt;
        exp_q.push_back(nxt);
        @(posedge clk);
    endtask

    initial begin : monitor
        ex_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("valid", {31'b0, o_valid}, {31'b0, e.valid});
                chk("illegal", {31'b0, o_illegal}, {31'b0, e.illegal});
                chk("ctrl", {28'b0, o_mem_read, o_mem_write, o_reg_write, 1'b0},
                    {28'b0, e.mem_read, e.mem_write, e.reg_write, 1'b0});
                if (e.valid) begin
                    chk("alu", {28'b0, o_alu_src, o_alu_op}, {28'b0, e.alu_src, e.alu_op});
                    chk("imm", o_imm, e.imm);
                    chk("src1", o_src1, e.src1);
                    chk("src2", o_src2, e.src2);
                    chk("regs", {17'b0, o_rs, o_rt, o_dest}, {17'b0, e.rs, e.rt, e.dest});
                end
            end
        end
    end

    function automatic logic [4:0] rreg();
        int k = $urandom_range(0, 4);
        case (k)
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd8;
            default: return 5'd9;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops[12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h3F};
        logic [5:0] fns[10] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h23, 6'h00};
        logic [5:0] op = ops[$urandom_range(0, 11)];
        logic [15:0] imm = 16'($urandom);
        if (op == 6'h00)
            return {op, rreg(), rreg(), rreg(), 5'd0, fns[$urandom_range(0, 9)]};
        return {op, rreg(), rreg(), imm};
    endfunction

    initial begin : stim
        logic [31:0] ins;
        logic s;
        rst = 1'b1;
        #1;
        chk("reset_valid", {31'b0, o_valid}, 32'h0);
        chk("reset_outs", {o_imm[15:0], o_dest, o_mem_read, o_mem_write, o_reg_write, o_illegal, o_alu_src, o_stall, 4'b0},
            32'h0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, {6'h08, 5'd0, 5'd8, 16'hFFFB}, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, s);
        #2;
        chk("addi_imm", o_imm, 32'hFFFF_FFFB);
        chk("addi_ctrl", {24'b0, o_alu_op, o_alu_src, o_reg_write, 3'b0}, {24'b0, 3'd0, 1'b1, 1'b1, 3'b0});
        chk("addi_dest", {27'b0, o_dest}, 32'd8);

        step(1'b1, {6'h23, 5'd0, 5'd8, 16'h0010}, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, s);
        ins = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
        step(1'b1, ins, 32'h11, 32'h22, 5'd0, 32'h0, 1'b0, 1'b0, s);
        #2;
        chk("lu_stall", {31'b0, s}, 32'h1);
        chk("lu_bubble", {31'b0, o_valid}, 32'h0);
        step(1'b1, ins, 32'h11, 32'h22, 5'd0, 32'h0, 1'b0, 1'b0, s);
        #2;
        chk("lu_once", {31'b0, s}, 32'h0);
        chk("lu_add_dest", {26'b0, o_valid, o_dest}, {26'b0, 1'b1, 5'd9});

        step(1'b1, {6'h00, 5'd9, 5'd10, 5'd11, 5'd0, 6'h20}, 32'h0, 32'h5, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b0, s);
        #2;
        chk("wb_bypass", o_src1, 32'hDEAD_BEEF);

        step(1'b1, {6'h08, 5'd1, 5'd2, 16'h0003}, 32'h1, 32'h2, 5'd0, 32'h0, 1'b1, 1'b1, s);
        #2;
        chk("flush_hold", {31'b0, o_valid}, 32'h0);

        step(1'b1, {6'h3F, 5'd1, 5'd2, 16'h0}, 32'h1, 32'h2, 5'd0, 32'h0, 1'b0, 1'b0, s);
        #2;
        chk("illegal_op", {29'b0, o_illegal, o_valid, o_reg_write}, {29'b0, 3'b100});

        step(1'b1, {6'h2B, 5'd1, 5'd2, 16'h0008}, 32'h1, 32'h2, 5'd0, 32'h0, 1'b0, 1'b0, s);
        #2;
        chk("sw_latched", {30'b0, o_valid, o_mem_write}, 32'h3);
        @(negedge clk);
        i_valid = 1'b0; i_hold = 1'b0; i_flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_reset", {o_src1[7:0], o_src2[7:0], o_rs, o_dest, o_valid, o_mem_write, o_alu_src, o_stall},
            32'h0);
        chk("mid_reset_imm", o_imm, 32'h0);
        st = '0;
        #1 rst = 1'b0;

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 7) != 0), rand_instr(), $urandom, $urandom,
                 rreg(), $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), s);
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
